// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding command/response to AXI4-Lite initiator with handshake timeout
module axi4_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [DATA_WIDTH-1:0]   o_rsp_data,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic wr;
  logic cmd_ready_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic rsp_valid_n, rsp_write_n, rsp_timeout_n;
  logic [DATA_WIDTH-1:0] rsp_data_n;
  logic [1:0] rsp_resp_n;
  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, busy, tmo;
  assign cmd_hs  = i_cmd_valid & o_cmd_ready;
  assign aw_hs   = o_awvalid & i_awready;
  assign w_hs    = o_wvalid & i_wready;
  assign b_hs    = i_bvalid & o_bready;
  assign ar_hs   = o_arvalid & i_arready;
  assign r_hs    = i_rvalid & o_rready;
  assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign busy    = state inside {WR_REQ, WR_RESP, RD_ADDR, RD_DATA};
  assign cnt_inc = cnt + CW'(1);
  // a handshake in the firing cycle takes priority over the timeout
  assign tmo     = (TIMEOUT_CYCLES != 0) && busy && !any_hs && (cnt_inc == TMO);
  always_comb begin
    state_n       = state;
    awvalid_n     = o_awvalid;
    wvalid_n      = o_wvalid;
    bready_n      = o_bready;
    arvalid_n     = o_arvalid;
    rready_n      = o_rready;
    rsp_valid_n   = o_rsp_valid;
    rsp_write_n   = o_rsp_write;
    rsp_data_n    = o_rsp_data;
    rsp_resp_n    = o_rsp_resp;
    rsp_timeout_n = o_rsp_timeout;
    cnt_n         = (busy && !any_hs) ? cnt_inc : '0;
    case (state)
      IDLE: if (cmd_hs) begin
        state_n   = i_cmd_write ? WR_REQ : RD_ADDR;
        awvalid_n = i_cmd_write;
        wvalid_n  = i_cmd_write;
        arvalid_n = !i_cmd_write;
      end
      WR_REQ: begin
        awvalid_n = o_awvalid & !i_awready;
        wvalid_n  = o_wvalid & !i_wready;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end
      end
      WR_RESP: if (b_hs) begin
        state_n       = RESP;
        bready_n      = 1'b0;
        rsp_valid_n   = 1'b1;
        rsp_write_n   = 1'b1;
        rsp_data_n    = '0;
        rsp_resp_n    = i_bresp;
        rsp_timeout_n = 1'b0;
      end
      RD_ADDR: if (ar_hs) begin
        state_n   = RD_DATA;
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
      end
      RD_DATA: if (r_hs) begin
        state_n       = RESP;
        rready_n      = 1'b0;
        rsp_valid_n   = 1'b1;
        rsp_write_n   = 1'b0;
        rsp_data_n    = i_rdata;
        rsp_resp_n    = i_rresp;
        rsp_timeout_n = 1'b0;
      end
      RESP: if (i_rsp_ready) begin
        state_n     = IDLE;
        rsp_valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    if (tmo) begin
      state_n       = RESP;
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_valid_n   = 1'b1;
      rsp_write_n   = wr;
      rsp_data_n    = '0;
      rsp_resp_n    = 2'b11;
      rsp_timeout_n = 1'b1;
    end
    cmd_ready_n = state_n == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wr            <= 1'b0;
      o_cmd_ready   <= 1'b0;
      o_awvalid     <= 1'b0;
      o_wvalid      <= 1'b0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_rready      <= 1'b0;
      o_awaddr      <= '0;
      o_araddr      <= '0;
      o_wdata       <= '0;
      o_wstrb       <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_write   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_resp    <= 2'b00;
      o_rsp_timeout <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      o_cmd_ready   <= cmd_ready_n;
      o_awvalid     <= awvalid_n;
      o_wvalid      <= wvalid_n;
      o_bready      <= bready_n;
      o_arvalid     <= arvalid_n;
      o_rready      <= rready_n;
      o_rsp_valid   <= rsp_valid_n;
      o_rsp_write   <= rsp_write_n;
      o_rsp_data    <= rsp_data_n;
      o_rsp_resp    <= rsp_resp_n;
      o_rsp_timeout <= rsp_timeout_n;
      if (cmd_hs) begin
        wr       <= i_cmd_write;
        o_awaddr <= i_cmd_addr;
        o_araddr <= i_cmd_addr;
        o_wdata  <= i_cmd_data;
        o_wstrb  <= i_cmd_strb;
      end
    end
  end
endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
AXI4-Lite initiator that turns a simple single-outstanding command/response interface into AXI4-Lite read and write transactions. It is the master-side counterpart of the team's AXI4-Lite register slaves and is used by host bridges and test logic to access those slaves. It handles one transaction at a time and reports a timeout if the slave stalls.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width; must be a multiple of 8.
STROBE_WIDTH, DATA_WIDTH/8, write strobe width.
TIMEOUT_CYCLES, 1024, maximum number of cycles to wait for any AXI handshake; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset: synchronous, active-high.
i_cmd_valid  in  1  command request.
o_cmd_ready  out  1  command is accepted when i_cmd_valid && o_cmd_ready.
i_cmd_write  in  1  1 = write, 0 = read.
i_cmd_addr  in  ADDR_WIDTH  transaction address.
i_cmd_data  in  DATA_WIDTH  write data.
i_cmd_strb  in  STROBE_WIDTH  write byte strobes.
o_rsp_valid  out  1  response available.
i_rsp_ready  in  1  response is consumed when o_rsp_valid && i_rsp_ready.
o_rsp_write  out  1  the response belongs to a write.
o_rsp_data  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
o_rsp_resp  out  2  AXI response code; 2'b11 on timeout.
o_rsp_timeout  out  1  the transaction was aborted by the timeout.
o_awvalid, i_awready, o_awaddr[ADDR_WIDTH]  AXI write address channel.
o_wvalid, i_wready, o_wdata[DATA_WIDTH], o_wstrb[STROBE_WIDTH]  AXI write data channel.
i_bvalid, o_bready, i_bresp[2]  AXI write response channel.
o_arvalid, i_arready, o_araddr[ADDR_WIDTH]  AXI read address channel.
i_rvalid, o_rready, i_rdata[DATA_WIDTH], i_rresp[2]  AXI read data channel.

Behaviour:
- Reset values: every output is 0, the state is IDLE and the timeout counter is 0. Reset aborts any transaction in flight; no response is produced for it.
- IDLE:
  - o_cmd_ready = 1.
  - On command acceptance, latch addr, data, strb and the write flag, and drop o_cmd_ready the next cycle.
  - Write: assert o_awvalid and o_wvalid together on the next cycle and go to WR_REQ.
  - Read: assert o_arvalid on the next cycle and go to RD_ADDR.
- WR_REQ:
  - o_awvalid and o_wvalid are independent. Each is held with stable payload until its own handshake, then drops the following cycle.
  - A handshake on both channels in the same cycle is legal.
  - Once both handshakes are complete, assert o_bready and go to WR_RESP.
- WR_RESP:
  - On i_bvalid && o_bready, capture i_bresp, drop o_bready, assert o_rsp_valid with o_rsp_write=1 and o_rsp_data=0, and go to RESP.
- RD_ADDR:
  - On i_arvalid... specifically on o_arvalid && i_arready, drop o_arvalid, assert o_rready and go to RD_DATA.
- RD_DATA:
  - On i_rvalid && o_rready, capture i_rdata and i_rresp, drop o_rready, assert o_rsp_valid with o_rsp_write=0, and go to RESP.
- RESP:
  - o_rsp_* outputs are held stable until i_rsp_ready.
  - On the response handshake, drop o_rsp_valid and return to IDLE; o_cmd_ready = 1 on the following cycle.
  - Minimum command-to-command spacing is therefore one IDLE cycle.
- AXI valid rule: no valid output ever depends combinationally on a ready input. Valids are registered and never withdrawn before their handshake, except on timeout.
- Timeout:
  - The counter clears on every state change and on every AXI handshake. It increments each cycle spent in WR_REQ, WR_RESP, RD_ADDR or RD_DATA.
  - When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), deassert all AXI valid and ready outputs and go to RESP with o_rsp_timeout=1, o_rsp_resp=2'b11 and o_rsp_data=0.
  - A handshake that occurs on the same cycle the timeout fires wins; the timeout is ignored.
- Responses SLVERR and DECERR from the slave are passed through unchanged with o_rsp_timeout=0.
- No more than one AXI transaction is outstanding at any time. A read and a write are never issued at the same time.

Test Plan:
- Write with slave ready=1 on all channels: command write addr=0, data=0xDEADBEEF, strb=0xF -> AW and W handshakes complete on the same cycle; then bresp=00 gives a response with write=1, resp=00, timeout=0.
- Read back with i_rdata=0xDEADBEEF and rresp=00 delayed by 3 cycles -> o_rsp_data=0xDEADBEEF, resp=00; o_arvalid is held high until i_arready.
- Write where the slave asserts awready 2 cycles before wready -> o_awvalid drops after its own handshake, o_wvalid stays high until wready, and exactly one B handshake follows.
- Read of an unmapped address where the slave returns rresp=11 -> o_rsp_resp=11, timeout=0. Then hold i_rsp_ready=0 for 5 cycles -> the response stays stable and o_cmd_ready stays 0.
- TIMEOUT_CYCLES=16 with the slave never asserting arready -> o_arvalid drops after 16 cycles; response has timeout=1, resp=11, data=0; the next command is accepted normally.
- Assert rst while in WR_RESP -> all outputs are 0 the next cycle; no response is issued; o_cmd_ready=1 the cycle after reset is released.
